// File: rtl/cache_refill_if.sv
// rtl/cache_refill_if.sv - single-outstanding req/gnt/rvalid memory read bus used by cache_refill
// master = refill unit side, slave = memory side.
interface cache_refill_if #(
  parameter int BITSIZE = 32
);
  logic               mem_req_o;
  logic [BITSIZE-1:0] mem_addr_o;
  logic               mem_gnt_i;
  logic               mem_rvalid_i;
  logic [BITSIZE-1:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input  mem_gnt_i,
    input  mem_rvalid_i,
    input  mem_rdata_i
  );

  modport slave (
    input  mem_req_o,
    input  mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );
endinterface

// File: rtl/cache_refill.sv
// rtl/cache_refill.sv - cache line refill FSM: fetches one line word-by-word and strobes it into the line store
// Optional critical-word-first fetch order enabled by CACHE_REFILL_CRITICAL_WORD_FIRST_EN.
module cache_refill #(
  parameter int N_CACHELINE_LENGTH = 4,
  parameter int BITSIZE            = 32
) (
  input  logic                                  clk,
  input  logic                                  resetn_i,
  input  logic                                  miss_i,
  input  logic [BITSIZE-1:0]                    miss_addr_i,
  input  logic                                  flush_i,
  output logic                                  busy_o,
  cache_refill_if.master                        mem,
  output logic [BITSIZE-1:0]                    line_addr_o,
  output logic [BITSIZE*N_CACHELINE_LENGTH-1:0] line_data_o,
  output logic                                  line_store_o,
  output logic                                  crit_valid_o,
  output logic [BITSIZE-1:0]                    crit_data_o
);

  localparam int OFFSIZE = $clog2(N_CACHELINE_LENGTH);
  localparam int LINEW   = BITSIZE * N_CACHELINE_LENGTH;
  localparam logic [BITSIZE-1:0] OFF_MASK = BITSIZE'(N_CACHELINE_LENGTH - 1);
  localparam logic [OFFSIZE-1:0] LAST_CNT = OFFSIZE'(N_CACHELINE_LENGTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    STORE,
    DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [BITSIZE-1:0]   base_q, base_d;
  logic [OFFSIZE-1:0]   cnt_q, cnt_d;
  logic [LINEW-1:0]     buf_q, buf_d;
  logic [BITSIZE-1:0]   line_addr_q, line_addr_d;
  logic [LINEW-1:0]     line_data_q, line_data_d;
  logic [OFFSIZE-1:0]   word_idx;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  logic [OFFSIZE-1:0]   crit_off_q, crit_off_d;
  logic                 crit_valid_q, crit_valid_d;
  logic [BITSIZE-1:0]   crit_data_q, crit_data_d;

  // Offset add wraps naturally in OFFSIZE bits, keeping the fetch inside the line.
  assign word_idx = crit_off_q + cnt_q;
`else
  assign word_idx = cnt_q;
`endif

  always_ff @(posedge clk) begin
    if (resetn_i) begin
      state_q     <= IDLE;
      base_q      <= '0;
      cnt_q       <= '0;
      buf_q       <= '0;
      line_addr_q <= '0;
      line_data_q <= '0;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
      crit_off_q   <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      buf_q       <= buf_d;
      line_addr_q <= line_addr_d;
      line_data_q <= line_data_d;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
      crit_off_q   <= crit_off_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    buf_d       = buf_q;
    line_addr_d = line_addr_q;
    line_data_d = line_data_q;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
    crit_off_d   = crit_off_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
`endif

    case (state_q)
      IDLE: begin
        if (miss_i) begin
          base_d  = miss_addr_i & ~OFF_MASK;
          cnt_d   = '0;
          state_d = REQ;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
          crit_off_d = miss_addr_i[OFFSIZE-1:0];
`endif
        end
      end

      REQ: begin
        // A grant taken together with flush leaves a read in flight that must be drained.
        if (flush_i) begin
          state_d = mem.mem_gnt_i ? DRAIN : IDLE;
        end else if (mem.mem_gnt_i) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (mem.mem_rvalid_i) begin
          if (flush_i) begin
            state_d = IDLE;
          end else begin
            buf_d[int'(word_idx)*BITSIZE +: BITSIZE] = mem.mem_rdata_i;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
            if (cnt_q == '0) begin
              crit_valid_d = 1'b1;
              crit_data_d  = mem.mem_rdata_i;
            end
`endif
            if (cnt_q == LAST_CNT) begin
              line_addr_d = base_q;
              line_data_d = buf_d;
              state_d     = STORE;
            end else begin
              cnt_d   = cnt_q + OFFSIZE'(1);
              state_d = REQ;
            end
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end

      STORE: state_d = IDLE;

      DRAIN: begin
        if (mem.mem_rvalid_i) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign busy_o         = (state_q != IDLE);
  assign mem.mem_req_o  = (state_q == REQ);
  assign mem.mem_addr_o = (state_q == REQ) ? (base_q | BITSIZE'(word_idx)) : '0;
  assign line_store_o   = (state_q == STORE);
  assign line_addr_o    = line_addr_q;
  assign line_data_o    = line_data_q;

`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  assign crit_valid_o = crit_valid_q;
  assign crit_data_o  = crit_data_q;
`else
  assign crit_valid_o = 1'b0;
  assign crit_data_o  = '0;
`endif

endmodule

// File: tb/tb_cache_refill.sv
// tb/tb_cache_refill.sv - self-checking bench for cache_refill against a line-level reference model
// Memory responder returns addr*3+key with programmable gnt/rvalid delays.
module tb_cache_refill;
  localparam int N  = 4;
  localparam int BW = 32;
`ifdef CACHE_REFILL_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            resetn_i;
  logic            miss_i;
  logic [BW-1:0]   miss_addr_i;
  logic            flush_i;
  logic            busy_o;
  logic [BW-1:0]   line_addr_o;
  logic [BW*N-1:0] line_data_o;
  logic            line_store_o;
  logic            crit_valid_o;
  logic [BW-1:0]   crit_data_o;

  cache_refill_if #(.BITSIZE(BW)) bus ();

  cache_refill #(.N_CACHELINE_LENGTH(N), .BITSIZE(BW)) dut (
    .clk          (clk),
    .resetn_i     (resetn_i),
    .miss_i       (miss_i),
    .miss_addr_i  (miss_addr_i),
    .flush_i      (flush_i),
    .busy_o       (busy_o),
    .mem          (bus),
    .line_addr_o  (line_addr_o),
    .line_data_o  (line_data_o),
    .line_store_o (line_store_o),
    .crit_valid_o (crit_valid_o),
    .crit_data_o  (crit_data_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            gnt_delay = 0;
  int            rv_delay = 1;
  bit            rand_delays = 1'b0;
  logic [31:0]   key = '0;
  int            req_cycles = 0;
  int            rv_left = 0;
  bit            pending = 1'b0;
  logic [31:0]   pend_addr, held_addr;
  logic [31:0]   grants[$];
  int            first_req_cyc = -1;
  int            first_rv_cyc = -1;
  int            addr_unstable = 0;
  int            store_count = 0;
  int            store_cyc = -1;
  int            busy_cycles = 0;
  int            crit_count = 0;
  int            crit_cyc = -1;
  logic [31:0]   crit_seen = '0;
  int            miss_cyc = 0;

  // Memory model: one outstanding read, gnt after gnt_delay held-request cycles, rvalid rv_delay cycles after gnt.
  initial begin
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      bus.mem_gnt_i    = 1'b0;
      bus.mem_rvalid_i = 1'b0;
      if (pending) begin
        rv_left--;
        if (rv_left == 0) begin
          bus.mem_rvalid_i = 1'b1;
          bus.mem_rdata_i  = pend_addr * 3 + key;
          pending = 1'b0;
          if (first_rv_cyc < 0) first_rv_cyc = cyc;
        end
      end
      if (bus.mem_req_o && !pending) begin
        if (req_cycles == 0) begin
          held_addr = bus.mem_addr_o;
          if (first_req_cyc < 0) first_req_cyc = cyc;
        end else if (bus.mem_addr_o !== held_addr) begin
          addr_unstable++;
        end
        if (req_cycles >= gnt_delay) begin
          bus.mem_gnt_i = 1'b1;
          grants.push_back(bus.mem_addr_o);
          pending    = 1'b1;
          pend_addr  = bus.mem_addr_o;
          rv_left    = rv_delay;
          req_cycles = 0;
          if (rand_delays) begin
            gnt_delay = $urandom_range(0, 3);
            rv_delay  = $urandom_range(1, 3);
          end
        end else begin
          req_cycles++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (line_store_o) begin
        store_count++;
        store_cyc = cyc;
      end
      if (busy_o) busy_cycles++;
      if (crit_valid_o) begin
        crit_count++;
        crit_cyc  = cyc;
        crit_seen = crit_data_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] line_base(input logic [31:0] a);
    return a & ~32'(N - 1);
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] a, input int i);
    int start;
    start = CWF ? int'(a % N) : 0;
    return line_base(a) + 32'((start + i) % N);
  endfunction

  function automatic logic [BW*N-1:0] model_line(input logic [31:0] a, input logic [31:0] k);
    logic [BW*N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r[i*BW +: BW] = (line_base(a) + 32'(i)) * 3 + k;
    return r;
  endfunction

  task automatic clr_stats();
    store_count   = 0;
    store_cyc     = -1;
    grants.delete();
    first_req_cyc = -1;
    first_rv_cyc  = -1;
    addr_unstable = 0;
    busy_cycles   = 0;
    crit_count    = 0;
    crit_cyc      = -1;
  endtask

  task automatic run_miss(input logic [31:0] a, input int budget, output bit ok);
    @(negedge clk);
    miss_i      = 1'b1;
    miss_addr_i = a;
    miss_cyc    = cyc;
    @(negedge clk);
    miss_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!busy_o) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    #1;
  endtask

  task automatic test_reset();
    resetn_i = 1'b1;
    miss_i = 1'b0;
    miss_addr_i = '0;
    flush_i = 1'b0;
    repeat (3) @(negedge clk);
    resetn_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_o); end
    checks++; if (bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", bus.mem_req_o); end
    checks++; if (bus.mem_addr_o !== '0) begin errors++; $display("FAIL reset_mem_addr got %h exp 0", bus.mem_addr_o); end
    checks++; if (line_store_o !== 1'b0) begin errors++; $display("FAIL reset_store got %b exp 0", line_store_o); end
    checks++; if (line_addr_o !== '0) begin errors++; $display("FAIL reset_line_addr got %h exp 0", line_addr_o); end
    checks++; if (line_data_o !== '0) begin errors++; $display("FAIL reset_line_data got %h exp 0", line_data_o); end
    checks++; if (crit_valid_o !== 1'b0 || crit_data_o !== '0) begin errors++; $display("FAIL reset_crit got %b/%h exp 0/0", crit_valid_o, crit_data_o); end
  endtask

  task automatic test_zero_wait();
    bit ok;
    logic [31:0] w;
    clr_stats();
    gnt_delay = 0; rv_delay = 1; rand_delays = 1'b0; key = '0;
    run_miss(32'h106, 100, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL zw_timeout got %b exp 1", ok); end
    checks++; if (first_req_cyc !== miss_cyc + 1) begin errors++; $display("FAIL zw_req_latency got %0d exp %0d", first_req_cyc, miss_cyc + 1); end
    checks++; if (store_count !== 1) begin errors++; $display("FAIL zw_store_count got %0d exp 1", store_count); end
    checks++; if (store_cyc !== miss_cyc + 2*N + 1) begin errors++; $display("FAIL zw_store_latency got %0d exp %0d", store_cyc, miss_cyc + 2*N + 1); end
    checks++; if (busy_cycles !== 2*N + 1) begin errors++; $display("FAIL zw_busy_cycles got %0d exp %0d", busy_cycles, 2*N + 1); end
    checks++; if (grants.size() !== N) begin errors++; $display("FAIL zw_grant_count got %0d exp %0d", grants.size(), N); end
    else for (int i = 0; i < N; i++) begin
      checks++; if (grants[i] !== model_addr(32'h106, i)) begin errors++; $display("FAIL zw_addr%0d got %h exp %h", i, grants[i], model_addr(32'h106, i)); end
    end
    checks++; if (line_addr_o !== 32'h104) begin errors++; $display("FAIL zw_line_addr got %h exp 00000104", line_addr_o); end
    checks++; if (line_data_o !== model_line(32'h106, key)) begin errors++; $display("FAIL zw_line_data got %h exp %h", line_data_o, model_line(32'h106, key)); end
    w = line_data_o[2*BW +: BW];
    checks++; if (w !== 32'h312) begin errors++; $display("FAIL zw_word2 got %h exp 00000312", w); end
    if (CWF) begin
      checks++; if (crit_count !== 1) begin errors++; $display("FAIL zw_crit_count got %0d exp 1", crit_count); end
      checks++; if (crit_seen !== 32'h312) begin errors++; $display("FAIL zw_crit_data got %h exp 00000312", crit_seen); end
      checks++; if (crit_cyc !== first_rv_cyc + 1) begin errors++; $display("FAIL zw_crit_cycle got %0d exp %0d", crit_cyc, first_rv_cyc + 1); end
    end else begin
      checks++; if (crit_count !== 0 || crit_data_o !== '0) begin errors++; $display("FAIL zw_crit_off got %0d/%h exp 0/0", crit_count, crit_data_o); end
    end
  endtask

  task automatic test_delayed();
    bit ok;
    clr_stats();
    gnt_delay = 3; rv_delay = 2; rand_delays = 1'b0; key = '0;
    run_miss(32'h106, 200, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL dl_timeout got %b exp 1", ok); end
    checks++; if (addr_unstable !== 0) begin errors++; $display("FAIL dl_addr_stable got %0d changes exp 0", addr_unstable); end
    checks++; if (grants.size() !== N) begin errors++; $display("FAIL dl_grant_count got %0d exp %0d", grants.size(), N); end
    checks++; if (store_count !== 1) begin errors++; $display("FAIL dl_store_count got %0d exp 1", store_count); end
    checks++; if (line_data_o !== model_line(32'h106, key)) begin errors++; $display("FAIL dl_line_data got %h exp %h", line_data_o, model_line(32'h106, key)); end
  endtask

  task automatic test_flush();
    bit ok;
    clr_stats();
    gnt_delay = 0; rv_delay = 4; rand_delays = 1'b0; key = '0;
    @(negedge clk);
    miss_i = 1'b1; miss_addr_i = 32'h106;
    @(negedge clk);
    miss_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      #2;
      if (grants.size() >= 3) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fl_third_grant_timeout got %b exp 1", ok); end
    @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    checks++; if (busy_o !== 1'b1) begin errors++; $display("FAIL fl_drain_busy got %b exp 1", busy_o); end
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!busy_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    #1;
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL fl_idle_timeout got %b exp 1", ok); end
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL fl_rvalid_consumed got %b exp 0", pending); end
    checks++; if (store_count !== 0) begin errors++; $display("FAIL fl_no_store got %0d exp 0", store_count); end
    checks++; if (grants.size() !== 3) begin errors++; $display("FAIL fl_grant_count got %0d exp 3", grants.size()); end
    clr_stats();
    rv_delay = 1; key = 32'h55;
    run_miss(32'h200, 100, ok);
    checks++; if (ok !== 1'b1 || store_count !== 1) begin errors++; $display("FAIL fl_refill_store got %b/%0d exp 1/1", ok, store_count); end
    checks++; if (line_addr_o !== 32'h200) begin errors++; $display("FAIL fl_refill_addr got %h exp 00000200", line_addr_o); end
    checks++; if (line_data_o !== model_line(32'h200, key)) begin errors++; $display("FAIL fl_refill_data got %h exp %h", line_data_o, model_line(32'h200, key)); end
  endtask

  task automatic test_miss_busy();
    bit ok;
    clr_stats();
    gnt_delay = 1; rv_delay = 1; rand_delays = 1'b0; key = 32'h7;
    @(negedge clk);
    miss_i = 1'b1; miss_addr_i = 32'h106;
    @(negedge clk);
    miss_i = 1'b0;
    repeat (2) @(negedge clk);
    miss_i = 1'b1; miss_addr_i = 32'h300;
    repeat (3) @(negedge clk);
    miss_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!busy_o) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    #1;
    checks++; if (ok !== 1'b1 || store_count !== 1) begin errors++; $display("FAIL mb_store got %b/%0d exp 1/1", ok, store_count); end
    checks++; if (line_addr_o !== 32'h104) begin errors++; $display("FAIL mb_line_addr got %h exp 00000104", line_addr_o); end
    checks++; if (line_data_o !== model_line(32'h106, key)) begin errors++; $display("FAIL mb_line_data got %h exp %h", line_data_o, model_line(32'h106, key)); end
    repeat (5) @(negedge clk);
    #1;
    checks++; if (busy_o !== 1'b0 || grants.size() !== N) begin errors++; $display("FAIL mb_not_queued got busy %b grants %0d exp 0 %0d", busy_o, grants.size(), N); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clr_stats();
    gnt_delay = 0; rv_delay = 5; rand_delays = 1'b0; key = '0;
    @(negedge clk);
    miss_i = 1'b1; miss_addr_i = 32'h106;
    @(negedge clk);
    miss_i = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      #2;
      if (grants.size() >= 1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rm_grant_timeout got %b exp 1", ok); end
    @(negedge clk);
    resetn_i = 1'b1;
    @(negedge clk);
    resetn_i = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    checks++; if (pending !== 1'b0) begin errors++; $display("FAIL rm_late_rvalid_sent got %b exp 0", pending); end
    checks++; if (busy_o !== 1'b0 || bus.mem_req_o !== 1'b0) begin errors++; $display("FAIL rm_idle got busy %b req %b exp 0 0", busy_o, bus.mem_req_o); end
    checks++; if (bus.mem_addr_o !== '0) begin errors++; $display("FAIL rm_mem_addr got %h exp 0", bus.mem_addr_o); end
    checks++; if (store_count !== 0 || line_store_o !== 1'b0) begin errors++; $display("FAIL rm_no_store got %0d exp 0", store_count); end
    checks++; if (line_addr_o !== '0) begin errors++; $display("FAIL rm_line_addr got %h exp 0", line_addr_o); end
    checks++; if (line_data_o !== '0) begin errors++; $display("FAIL rm_line_data got %h exp 0", line_data_o); end
    checks++; if (crit_valid_o !== 1'b0 || crit_data_o !== '0) begin errors++; $display("FAIL rm_crit got %b/%h exp 0/0", crit_valid_o, crit_data_o); end
    checks++; if (grants.size() !== 1) begin errors++; $display("FAIL rm_grant_count got %0d exp 1", grants.size()); end
  endtask

  task automatic test_random();
    bit ok;
    logic [31:0] a;
    for (int it = 0; it < 8; it++) begin
      clr_stats();
      a = $urandom & 32'h000F_FFFF;
      key = $urandom;
      rand_delays = 1'b1;
      gnt_delay = $urandom_range(0, 3);
      rv_delay  = $urandom_range(1, 3);
      run_miss(a, 200, ok);
      checks++; if (ok !== 1'b1 || store_count !== 1) begin errors++; $display("FAIL rnd%0d_store got %b/%0d exp 1/1", it, ok, store_count); end
      checks++; if (line_addr_o !== line_base(a)) begin errors++; $display("FAIL rnd%0d_line_addr got %h exp %h", it, line_addr_o, line_base(a)); end
      checks++; if (line_data_o !== model_line(a, key)) begin errors++; $display("FAIL rnd%0d_line_data got %h exp %h", it, line_data_o, model_line(a, key)); end
      checks++; if (addr_unstable !== 0) begin errors++; $display("FAIL rnd%0d_addr_stable got %0d exp 0", it, addr_unstable); end
      checks++; if (grants.size() !== N) begin errors++; $display("FAIL rnd%0d_grant_count got %0d exp %0d", it, grants.size(), N); end
      else for (int i = 0; i < N; i++) begin
        checks++; if (grants[i] !== model_addr(a, i)) begin errors++; $display("FAIL rnd%0d_addr%0d got %h exp %h", it, i, grants[i], model_addr(a, i)); end
      end
    end
    rand_delays = 1'b0;
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_delayed();
    test_flush();
    test_miss_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
